cr_kme_bimc_chain_master: RTL and testbench

Serial master for the KME BIMC (built-in memory controller) daisy chain. It takes one parallel command frame, shifts it out on `bimc_odat` with a `bimc_osync` frame marker, and captures the frame that returns from the end of the chain on `bimc_idat`/`bimc_isync`. The captured frame is presented on a valid/ack response port. The block is the driving end of the chain that the RAM FIFOs and other memory wrappers in `cr_kme` pass through, and it sits between the register interface and the first chain member.

---
 rtl/cr_kme_bimc_chain_master.sv | 215 +++++++++++++++++++++
 tb/tb_cr_kme_bimc_chain_master.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cr_kme_bimc_chain_master.sv
// KME BIMC daisy-chain serial master.
// Shifts one parallel command frame out on bimc_odat (bimc_osync marks the first bit), captures
// the frame returning from the end of the chain and presents it on a valid/ack response port.
// Optional feature macro: CR_KME_BIMC_PARITY_EN appends an even-parity bit to the tx frame and
// checks the parity bit of the returned frame.
module cr_kme_bimc_chain_master #(
    parameter int unsigned FRAME_W = 32,
    parameter int unsigned TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [FRAME_W-1:0] cmd_data,
    input  logic               cmd_valid,
    output logic               cmd_ready,
    output logic [FRAME_W-1:0] rsp_data,
    output logic               rsp_valid,
    input  logic               rsp_ack,
    output logic               rsp_timeout,
    output logic               rsp_sync_err,
    output logic               rsp_perr,
    output logic               bimc_odat,
    output logic               bimc_osync,
    input  logic               bimc_idat,
    input  logic               bimc_isync
);

`ifdef CR_KME_BIMC_PARITY_EN
    localparam int unsigned FRM_L = FRAME_W + 1;
`else
    localparam int unsigned FRM_L = FRAME_W;
`endif
    localparam int unsigned CNT_W = $clog2(FRM_L + 1);
    localparam int unsigned TO_W  = $clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRM_L);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(FRM_L - 1);
    localparam logic [TO_W-1:0]  TO_ONE   = TO_W'(1);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    logic [1:0]         r_state;
    logic [1:0]         w_state_d;

    logic [FRM_L-1:0]   r_tx_sr;      // bits still to be sent, next bit at the MSB
    logic [CNT_W-1:0]   r_tx_cnt;     // bits already placed on bimc_odat
    logic               r_odat;
    logic               r_osync;

    logic [FRM_L-1:0]   r_rx_sr;
    logic [CNT_W-1:0]   r_rx_cnt;     // bits captured so far
    logic               r_rx_act;
    logic               r_rx_done;
    logic               r_sync_err;

    logic [TO_W-1:0]    r_to_cnt;

    logic               r_rsp_valid;
    logic [FRAME_W-1:0] r_rsp_data;
    logic               r_rsp_timeout;
    logic               r_rsp_perr;

    logic [FRM_L-1:0]   w_tx_frame;
    logic [FRM_L-1:0]   w_rx_next;
    logic [FRM_L-1:0]   w_rx_frame;
    logic [FRAME_W-1:0] w_rsp_frame;
    logic               w_perr;
    logic               w_accept;
    logic               w_busy;
    logic               w_tx_done;
    logic               w_rx_start;
    logic               w_rx_last;
    logic               w_done;
    logic               w_timeout;
    logic               w_exit;

`ifdef CR_KME_BIMC_PARITY_EN
    assign w_tx_frame  = {cmd_data, ^cmd_data};
    assign w_rsp_frame = w_rx_frame[FRM_L-1:1];
    assign w_perr      = w_rx_frame[0] ^ (^w_rx_frame[FRM_L-1:1]);
`else
    assign w_tx_frame  = cmd_data;
    assign w_rsp_frame = w_rx_frame;
    assign w_perr      = 1'b0;
`endif

    assign w_accept   = (r_state == ST_IDLE) & cmd_valid;
    assign w_busy     = (r_state == ST_BUSY);
    assign w_tx_done  = (r_tx_cnt == CNT_FULL);
    // Capture is single-shot per command; isync after the frame has been taken is ignored.
    assign w_rx_start = w_busy & ~r_rx_act & ~r_rx_done & bimc_isync;
    assign w_rx_last  = w_busy & r_rx_act & (r_rx_cnt == CNT_LAST);
    assign w_rx_next  = {r_rx_sr[FRM_L-2:0], bimc_idat};
    // The last bit is sampled in the exit cycle, so take it straight from the input.
    assign w_rx_frame = r_rx_done ? r_rx_sr : w_rx_next;
    assign w_done     = w_busy & w_tx_done & (r_rx_done | w_rx_last);
    assign w_timeout  = w_busy & (r_to_cnt == TO_LAST) & ~w_done;
    assign w_exit     = w_done | w_timeout;

    assign cmd_ready    = (r_state == ST_IDLE);
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign rsp_timeout  = r_rsp_timeout;
    assign rsp_sync_err = r_sync_err;
    assign rsp_perr     = r_rsp_perr;
    assign bimc_odat    = r_odat;
    assign bimc_osync   = r_osync;

    // Next-state decode for the IDLE/BUSY/RESP sequencer.
    always_comb begin
        w_state_d = r_state;
        case (r_state)
            ST_IDLE: if (cmd_valid) w_state_d = ST_BUSY;
            ST_BUSY: if (w_exit)    w_state_d = ST_RESP;
            ST_RESP: if (rsp_ack)   w_state_d = ST_IDLE;
            default:                w_state_d = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= ST_IDLE;
        else        r_state <= w_state_d;
    end

    // Transmitter: first bit and osync go out in the cycle after acceptance; abandoned on timeout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tx_sr  <= '0;
            r_tx_cnt <= '0;
            r_odat   <= 1'b0;
            r_osync  <= 1'b0;
        end else if (w_accept) begin
            r_tx_sr  <= {w_tx_frame[FRM_L-2:0], 1'b0};
            r_tx_cnt <= CNT_ONE;
            r_odat   <= w_tx_frame[FRM_L-1];
            r_osync  <= 1'b1;
        end else if (w_busy) begin
            r_osync <= 1'b0;
            if (w_exit || w_tx_done) begin
                r_odat <= 1'b0;
            end else begin
                r_odat   <= r_tx_sr[FRM_L-1];
                r_tx_sr  <= {r_tx_sr[FRM_L-2:0], 1'b0};
                r_tx_cnt <= r_tx_cnt + CNT_ONE;
            end
        end
    end

    // Receiver: isync starts capture with that cycle's idat as the MSB; extra isync flags an error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rx_sr    <= '0;
            r_rx_cnt   <= '0;
            r_rx_act   <= 1'b0;
            r_rx_done  <= 1'b0;
            r_sync_err <= 1'b0;
        end else if (w_accept) begin
            r_rx_cnt   <= '0;
            r_rx_act   <= 1'b0;
            r_rx_done  <= 1'b0;
            r_sync_err <= 1'b0;
        end else if (w_busy) begin
            if (w_rx_start) begin
                r_rx_sr  <= w_rx_next;
                r_rx_cnt <= CNT_ONE;
                r_rx_act <= 1'b1;
            end else if (r_rx_act) begin
                r_rx_sr  <= w_rx_next;
                r_rx_cnt <= r_rx_cnt + CNT_ONE;
                if (bimc_isync) r_sync_err <= 1'b1;
                if (w_rx_last) begin
                    r_rx_act  <= 1'b0;
                    r_rx_done <= 1'b1;
                end
            end
        end
    end

    // Timeout counter: counts every BUSY cycle from acceptance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        r_to_cnt <= '0;
        else if (w_accept) r_to_cnt <= '0;
        else if (w_busy)   r_to_cnt <= r_to_cnt + TO_ONE;
    end

    // Response register: loaded on BUSY exit, held until acknowledged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid   <= 1'b0;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b0;
            r_rsp_perr    <= 1'b0;
        end else if (w_accept) begin
            r_rsp_timeout <= 1'b0;
            r_rsp_perr    <= 1'b0;
        end else if (w_done) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= w_rsp_frame;
            r_rsp_timeout <= 1'b0;
            r_rsp_perr    <= w_perr;
        end else if (w_timeout) begin
            r_rsp_valid   <= 1'b1;
            r_rsp_data    <= '0;
            r_rsp_timeout <= 1'b1;
            r_rsp_perr    <= 1'b0;
        end else if ((r_state == ST_RESP) && rsp_ack) begin
            r_rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_cr_kme_bimc_chain_master.sv
// Scoreboard bench for cr_kme_bimc_chain_master with a behavioural chain model
// (delay line, open chain, isync injection, bit flip). Honours CR_KME_BIMC_PARITY_EN.
module tb_cr_kme_bimc_chain_master;

    localparam int FW = 32;
    localparam int TO = 64;
`ifdef CR_KME_BIMC_PARITY_EN
    localparam int L = FW + 1;
`else
    localparam int L = FW;
`endif

    typedef struct {
        logic [FW-1:0] data;
        logic          to;
        logic          se;
        logic          pe;
        int            lat;
        int            t_acc;
    } exp_t;

    logic          clk;
    logic          rst_n;
    logic [FW-1:0] cmd_data;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [FW-1:0] rsp_data;
    logic          rsp_valid;
    logic          rsp_ack;
    logic          rsp_timeout;
    logic          rsp_sync_err;
    logic          rsp_perr;
    logic          bimc_odat;
    logic          bimc_osync;
    logic          bimc_idat;
    logic          bimc_isync;

    logic [3:0]    ch_dly  = 4'd0;
    logic          ch_open = 1'b0;
    logic          inj     = 1'b0;
    logic          flip    = 1'b0;
    logic [15:0]   h_dat   = '0;
    logic [15:0]   h_sync  = '0;
    logic          d_raw;
    logic          s_raw;

    int   cyc      = 0;
    int   n_tests  = 0;
    int   n_fail   = 0;
    logic mon_prev = 1'b0;
    exp_t sb_q[$];

    cr_kme_bimc_chain_master #(
        .FRAME_W (FW),
        .TIMEOUT (TO)
    ) u_dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cmd_data     (cmd_data),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .rsp_data     (rsp_data),
        .rsp_valid    (rsp_valid),
        .rsp_ack      (rsp_ack),
        .rsp_timeout  (rsp_timeout),
        .rsp_sync_err (rsp_sync_err),
        .rsp_perr     (rsp_perr),
        .bimc_odat    (bimc_odat),
        .bimc_osync   (bimc_osync),
        .bimc_idat    (bimc_idat),
        .bimc_isync   (bimc_isync)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Chain model: delay line of the master's own output.
    always @(posedge clk) begin
        h_dat  <= {h_dat[14:0], bimc_odat};
        h_sync <= {h_sync[14:0], bimc_osync};
    end

    always_comb begin
        d_raw = bimc_odat;
        s_raw = bimc_osync;
        if (ch_dly != 4'd0) begin
            d_raw = h_dat[ch_dly - 4'd1];
            s_raw = h_sync[ch_dly - 4'd1];
        end
        if (ch_open) begin
            d_raw = 1'b0;
            s_raw = 1'b0;
        end
        bimc_idat  = d_raw ^ flip;
        bimc_isync = s_raw | inj;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Monitor: compare each new response against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (rsp_valid && !mon_prev) begin
            if (sb_q.size() == 0) begin
                check("rsp_unexpected", 64'(rsp_valid), 64'd0);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", 64'(rsp_data), 64'(e.data));
                check("rsp_timeout", 64'(rsp_timeout), 64'(e.to));
                check("rsp_sync_err", 64'(rsp_sync_err), 64'(e.se));
                check("rsp_perr", 64'(rsp_perr), 64'(e.pe));
                check("rsp_latency", 64'(cyc - e.t_acc + 1), 64'(e.lat));
            end
        end
        mon_prev <= rsp_valid;
    end

    // Called at a negedge while idle; returns at the negedge of the first bit cycle.
    task automatic send(input logic [FW-1:0] d, output int t_acc);
        check("cmd_ready_pre", 64'(cmd_ready), 64'd1);
        cmd_data  = d;
        cmd_valid = 1'b1;
        t_acc     = cyc + 1;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic push_exp(input logic [FW-1:0] d, input logic to, input logic se,
                            input logic pe, input int lat, input int t_acc);
        exp_t e;
        e.data  = d;
        e.to    = to;
        e.se    = se;
        e.pe    = pe;
        e.lat   = lat;
        e.t_acc = t_acc;
        sb_q.push_back(e);
    endtask

    task automatic wait_rsp(input int budget);
        int n = 0;
        while (!rsp_valid && n < budget) begin
            @(negedge clk);
            n++;
        end
        if (!rsp_valid) check("rsp_wait", 64'(rsp_valid), 64'd1);
    endtask

    task automatic ack_rsp();
        rsp_ack = 1'b1;
        @(negedge clk);
        rsp_ack = 1'b0;
        check("ready_after_ack", 64'(cmd_ready), 64'd1);
        check("valid_after_ack", 64'(rsp_valid), 64'd0);
    endtask

    task automatic run_lb(input logic [FW-1:0] d, input logic [3:0] dly);
        int t;
        ch_dly = dly;
        send(d, t);
        push_exp(d, 1'b0, 1'b0, 1'b0, L + 1 + int'(dly), t);
        wait_rsp(200);
        ack_rsp();
    endtask

    initial begin
        repeat (20000) @(posedge clk);
        $display("FAIL watchdog: got timeout, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        rst_n     = 1'b0;
        cmd_data  = '0;
        cmd_valid = 1'b0;
        rsp_ack   = 1'b0;
        repeat (3) @(negedge clk);

        check("rst_cmd_ready", 64'(cmd_ready), 64'd1);
        check("rst_rsp_valid", 64'(rsp_valid), 64'd0);
        check("rst_rsp_data", 64'(rsp_data), 64'd0);
        check("rst_rsp_timeout", 64'(rsp_timeout), 64'd0);
        check("rst_rsp_sync_err", 64'(rsp_sync_err), 64'd0);
        check("rst_rsp_perr", 64'(rsp_perr), 64'd0);
        check("rst_odat", 64'(bimc_odat), 64'd0);
        check("rst_osync", 64'(bimc_osync), 64'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Plain loopback, also checking the first transmitted bit.
        ch_dly = 4'd0;
        send(32'hA5C3_0F81, t);
        check("first_osync", 64'(bimc_osync), 64'd1);
        check("first_odat", 64'(bimc_odat), 64'd1);
        push_exp(32'hA5C3_0F81, 1'b0, 1'b0, 1'b0, L + 1, t);
        wait_rsp(200);
        ack_rsp();

        // Five-cycle delay line with the response held for ten cycles.
        ch_dly = 4'd5;
        send(32'h3C5A_9617, t);
        push_exp(32'h3C5A_9617, 1'b0, 1'b0, 1'b0, L + 6, t);
        wait_rsp(200);
        for (int i = 0; i < 10; i++) begin
            cmd_valid = 1'b1;
            cmd_data  = 32'h0BAD_F00D;
            check("hold_valid", 64'(rsp_valid), 64'd1);
            check("hold_not_ready", 64'(cmd_ready), 64'd0);
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        ack_rsp();

        // Open chain: timeout with zero data, tx silenced.
        ch_open = 1'b1;
        send(32'hDEAD_BEEF, t);
        push_exp('0, 1'b1, 1'b0, 1'b0, TO + 1, t);
        wait_rsp(200);
        check("to_odat", 64'(bimc_odat), 64'd0);
        check("to_osync", 64'(bimc_osync), 64'd0);
        @(negedge clk);
        check("to_odat_late", 64'(bimc_odat), 64'd0);
        check("to_osync_late", 64'(bimc_osync), 64'd0);
        ack_rsp();
        ch_open = 1'b0;

        // Extra isync four cycles into capture.
        ch_dly = 4'd0;
        send(32'h1234_5678, t);
        push_exp(32'h1234_5678, 1'b0, 1'b1, 1'b0, L + 1, t);
        repeat (4) @(negedge clk);
        inj = 1'b1;
        @(negedge clk);
        inj = 1'b0;
        wait_rsp(200);
        ack_rsp();

        // Reset mid-frame: nothing expected from the aborted command.
        send(32'hFFFF_0000, t);
        repeat (9) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("mid_rst_ready", 64'(cmd_ready), 64'd1);
        check("mid_rst_odat", 64'(bimc_odat), 64'd0);
        check("mid_rst_osync", 64'(bimc_osync), 64'd0);
        check("mid_rst_valid", 64'(rsp_valid), 64'd0);
        check("mid_rst_data", 64'(rsp_data), 64'd0);
        check("mid_rst_flags", 64'({rsp_timeout, rsp_sync_err, rsp_perr}), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_ready", 64'(cmd_ready), 64'd1);
        check("post_rst_valid", 64'(rsp_valid), 64'd0);
        run_lb(32'h0F0F_A5A5, 4'd0);

        run_lb(32'h0000_0001, 4'd0);

`ifdef CR_KME_BIMC_PARITY_EN
        // Corrupt the parity bit (last bit on the wire, cycle T+L).
        ch_dly = 4'd0;
        send(32'h0000_0001, t);
        push_exp(32'h0000_0001, 1'b0, 1'b0, 1'b1, L + 1, t);
        repeat (L - 1) @(negedge clk);
        flip = 1'b1;
        @(negedge clk);
        flip = 1'b0;
        wait_rsp(200);
        ack_rsp();
`endif

        for (int i = 0; i < 4; i++) begin
            run_lb(FW'($urandom), 4'($urandom_range(0, 8)));
        end

        repeat (3) @(negedge clk);
        check("sb_empty", 64'(sb_q.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
